// File: rtl/ctrl_pkg.sv
// Shared step numbering, FSM state encoding and decode helper for the instruction sequencer.
package ctrl_pkg;

  typedef enum logic {
    ST_HALT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // Action steps; the odd step after each one settles or waits on memory.
  localparam logic [3:0] T_FETCH_AR = 4'd0;
  localparam logic [3:0] T_FETCH_IR = 4'd2;
  localparam logic [3:0] T_DECODE   = 4'd4;
  localparam logic [3:0] T_INDIR    = 4'd6;
  localparam logic [3:0] T_OPER     = 4'd8;
  localparam logic [3:0] T_EXEC     = 4'd10;

  localparam logic [3:0] T_REG_END  = T_INDIR + 4'd1;
  localparam logic [3:0] T_MEM_END  = T_EXEC + 4'd1;

  localparam logic [3:0] T_IR_WAIT    = T_FETCH_IR + 4'd1;
  localparam logic [3:0] T_INDIR_WAIT = T_INDIR + 4'd1;
  localparam logic [3:0] T_OPER_WAIT  = T_OPER + 4'd1;

  localparam int OP_REGIO = 7;
  localparam int HLT_BIT  = 0;

  function automatic logic [7:0] op_onehot(input logic [2:0] op);
    op_onehot = 8'b0000_0001 << op;
  endfunction

endpackage

// File: rtl/sc_decoder.sv
// 4-to-16 one-hot decoder with enable; produces the T0..T15 timing vector from SC.
module sc_decoder
  import ctrl_pkg::*;
(
  input  logic [3:0]  sel_i,
  input  logic        en_i,
  output logic [15:0] onehot_o
);

  always_comb begin
    onehot_o = 16'h0000;
    if (en_i) begin
      onehot_o[sel_i] = 1'b1;
    end
  end

endmodule

// File: rtl/seq_ctrl.sv
// Instruction sequencer: owns SC, HALT/RUN control, single-step and memory wait stretching.
// Produces the one-hot timing vector and the opcode decode latched at T4.
module seq_ctrl
  import ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        step,
  input  logic        mem_rdy,
  input  logic [15:0] ir_odat,
  output logic [15:0] dec_signal,
  output logic [7:0]  dec,
  output logic [3:0]  sc_value,
  output logic        running,
  output logic        instr_done
);

  state_t     state_q, state_d;
  logic [3:0] sc_q, sc_d;
  logic       step_mode_q, step_mode_d;
  logic [7:0] dec_q, dec_d;

  logic is_regio;
  logic is_hlt;
  logic end_step;
  logic mem_wait;

  assign is_regio = dec_q[OP_REGIO];
  assign is_hlt   = is_regio & ~ir_odat[15] & ir_odat[HLT_BIT];
  assign end_step = is_regio ? (sc_q == T_REG_END) : (sc_q == T_MEM_END);

  // The T7 wait only applies to indirect memory-ref; T9 to any memory-ref.
  assign mem_wait = ~mem_rdy &
                    ((sc_q == T_IR_WAIT) |
                     ((sc_q == T_INDIR_WAIT) & ~is_regio & ir_odat[15]) |
                     ((sc_q == T_OPER_WAIT) & ~is_regio));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_HALT;
      sc_q        <= T_FETCH_AR;
      step_mode_q <= 1'b0;
      dec_q       <= 8'h00;
    end else begin
      state_q     <= state_d;
      sc_q        <= sc_d;
      step_mode_q <= step_mode_d;
      dec_q       <= dec_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    sc_d        = sc_q;
    step_mode_d = step_mode_q;
    dec_d       = dec_q;
    case (state_q)
      ST_HALT: begin
        sc_d = T_FETCH_AR;
        if (start || step) begin
          state_d     = ST_RUN;
          step_mode_d = step;
        end
      end
      ST_RUN: begin
        if (sc_q == T_DECODE) begin
          dec_d = op_onehot(ir_odat[14:12]);
        end
        // T12..T15 are unreachable in legal operation; recover to T0.
        if (sc_q > T_MEM_END) begin
          sc_d = T_FETCH_AR;
        end else if (end_step) begin
          sc_d = T_FETCH_AR;
          if (is_hlt || step_mode_q) begin
            state_d     = ST_HALT;
            step_mode_d = 1'b0;
          end
        end else if (!mem_wait) begin
          sc_d = sc_q + 4'd1;
        end
      end
      default: begin
        state_d = ST_HALT;
        sc_d    = T_FETCH_AR;
      end
    endcase
  end

  always_comb begin
    running    = (state_q == ST_RUN);
    instr_done = (state_q == ST_RUN) & end_step;
    dec        = dec_q;
    sc_value   = sc_q;
  end

  sc_decoder u_sc_decoder (
    .sel_i    (sc_q),
    .en_i     (running),
    .onehot_o (dec_signal)
  );

endmodule

// File: tb/tb_seq_ctrl.sv
// Directed bench for seq_ctrl: HLT, memory-ref, indirect with waits, step mode, reset and SC recovery.
module tb_seq_ctrl;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        step;
  logic        mem_rdy;
  logic [15:0] ir_odat;
  logic [15:0] dec_signal;
  logic [7:0]  dec;
  logic [3:0]  sc_value;
  logic        running;
  logic        instr_done;

  int checks = 0;
  int errors = 0;

  seq_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .step       (step),
    .mem_rdy    (mem_rdy),
    .ir_odat    (ir_odat),
    .dec_signal (dec_signal),
    .dec        (dec),
    .sc_value   (sc_value),
    .running    (running),
    .instr_done (instr_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_halted(input string tag);
    check({tag, " running"}, {15'h0, running}, 16'h0000);
    check({tag, " dec_signal"}, dec_signal, 16'h0000);
    check({tag, " sc_value"}, {12'h0, sc_value}, 16'h0000);
  endtask

  // Issue a one-cycle start/step pulse from HALT; returns at the T0 sample point.
  task automatic go(input logic s, input logic st);
    start = s;
    step  = st;
    @(negedge clk);
    start = 1'b0;
    step  = 1'b0;
  endtask

  // Walk one instruction from T0 to its last step, checking the timing vector every cycle.
  // mem_rdy is pulled low for wait_n cycles while on step wait_sc; start pulses at step start_at.
  task automatic run_instr(input string tag, input int last, input int wait_sc, input int wait_n,
                           input logic [7:0] exp_dec, input int start_at);
    int sc;
    int w;
    logic [15:0] one;
    sc  = 0;
    w   = 0;
    one = 16'h0001;
    while (sc <= last) begin
      check($sformatf("%s T%0d dec_signal", tag, sc), dec_signal, one << sc);
      check($sformatf("%s T%0d instr_done", tag, sc), {15'h0, instr_done},
            {15'h0, (sc == last)});
      if (sc == 5 && w == 0) check($sformatf("%s dec", tag), {8'h00, dec}, {8'h00, exp_dec});
      start = (sc == start_at);
      if (sc == wait_sc && w < wait_n) begin
        mem_rdy = 1'b0;
        w++;
      end else begin
        mem_rdy = 1'b1;
        sc++;
      end
      @(negedge clk);
    end
    start   = 1'b0;
    mem_rdy = 1'b1;
  endtask

  initial begin
    rst_n   = 1'b1;
    start   = 1'b0;
    step    = 1'b0;
    mem_rdy = 1'b1;
    ir_odat = 16'h7001;
    #2 rst_n = 1'b0;
    #1;
    check_halted("reset");
    check("reset dec", {8'h00, dec}, 16'h0000);
    check("reset instr_done", {15'h0, instr_done}, 16'h0000);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check_halted("idle");

    // HLT instruction: T0..T7 then HALT, dec holds.
    ir_odat = 16'h7001;
    go(1'b1, 1'b0);
    run_instr("hlt", 7, -1, 0, 8'h80, -1);
    check_halted("after hlt");
    check("after hlt dec held", {8'h00, dec}, 16'h0080);

    // Direct memory-ref, 12 cycles, then wraps to T0 and keeps running.
    ir_odat = 16'h1005;
    go(1'b1, 1'b0);
    run_instr("memref", 11, -1, 0, 8'h02, -1);
    check("memref wrap sc", {12'h0, sc_value}, 16'h0000);
    check("memref wrap running", {15'h0, running}, 16'h0001);
    ir_odat = 16'h7001;
    run_instr("hlt after memref", 7, -1, 0, 8'h80, -1);
    check_halted("after memref");

    // Indirect via step with start also high: step wins, T7 stretched by 3 cycles.
    ir_odat = 16'h9005;
    go(1'b1, 1'b1);
    run_instr("indirect", 11, 7, 3, 8'h02, -1);
    check_halted("after indirect step");

    // Register-ref (not HLT) in step mode; start during RUN is ignored.
    ir_odat = 16'h7800;
    go(1'b0, 1'b1);
    run_instr("step regref", 7, -1, 0, 8'h80, 3);
    check_halted("after step regref");
    repeat (2) @(negedge clk);
    check_halted("still halted");

    // Reset dropped at T9 of a memory-ref.
    ir_odat = 16'h1005;
    go(1'b1, 1'b0);
    repeat (9) @(negedge clk);
    check("pre-reset T9", dec_signal, 16'h0200);
    mem_rdy = 1'b0;
    rst_n   = 1'b0;
    #1;
    check_halted("mid reset");
    check("mid reset dec", {8'h00, dec}, 16'h0000);
    check("mid reset instr_done", {15'h0, instr_done}, 16'h0000);
    @(negedge clk);
    rst_n   = 1'b1;
    mem_rdy = 1'b1;
    repeat (3) @(negedge clk);
    check_halted("post reset");

    // Illegal SC value recovers to T0 on the next cycle.
    ir_odat = 16'h7800;
    go(1'b1, 1'b0);
    dut.sc_q = 4'd13;
    #1;
    check("forced sc", {12'h0, sc_value}, 16'h000D);
    check("forced dec_signal", dec_signal, 16'h2000);
    @(negedge clk);
    check("recovered sc", {12'h0, sc_value}, 16'h0000);
    check("recovered dec_signal", dec_signal, 16'h0001);
    ir_odat = 16'h7001;
    run_instr("hlt final", 7, -1, 0, 8'h80, -1);
    check_halted("final");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
